// File: rtl/mod_counter_gen_if.sv
// Control/status bundle for one mod_counter_gen stage.
// The master drives the controls and the slave (the counter) returns its state.
interface mod_counter_gen_if #(
   parameter int WIDTH   = 4,
   parameter int TALLY_W = 4
);
   logic               en;
   logic               up_dn;
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic               tally_clr;
   logic [WIDTH-1:0]   count;
   logic               tc;
   logic               wrap;
   logic [TALLY_W-1:0] tally;

   modport master (
      output en, up_dn, load, load_val, tally_clr,
      input  count, tc, wrap, tally
   );

   modport slave (
      input  en, up_dn, load, load_val, tally_clr,
      output count, tc, wrap, tally
   );
endinterface

// File: rtl/mod_counter_gen.sv
// Parametrised up/down modulo-N counter with load, cascade terminal count,
// registered wrap pulse and saturating wrap tally.
module mod_counter_gen #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10,
   parameter int TALLY_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mod_counter_gen_if.slave     bus
);
   generate
      if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
         $error("mod_counter_gen: MODULUS out of range for WIDTH");
      end
      if ($bits(bus.count) != WIDTH || $bits(bus.tally) != TALLY_W) begin : g_bad_bus
         $error("mod_counter_gen: interface widths do not match parameters");
      end
   endgenerate

   // One extra bit so MODULUS == 2**WIDTH is representable in compares.
   localparam logic [WIDTH:0]     MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]     MAX_W = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0]     ONE_W = (WIDTH+1)'(1);
   localparam logic [TALLY_W-1:0] T_MAX = '1;
   localparam logic [TALLY_W-1:0] T_ONE = TALLY_W'(1);

   logic [WIDTH-1:0]   count_q;
   logic               wrap_q;
   logic [TALLY_W-1:0] tally_q;

   logic [WIDTH:0]     cnt_ext;
   logic [WIDTH:0]     load_ext;
   logic [WIDTH:0]     nxt;
   logic [WIDTH-1:0]   ld_val;
   logic               step_wrap;
   logic               wrap_edge;

   assign cnt_ext  = {1'b0, count_q};
   assign load_ext = {1'b0, bus.load_val};
   assign ld_val   = (load_ext < MOD_W) ? bus.load_val : MAX_W[WIDTH-1:0];

   // An out-of-range count recovers to 0 and is treated as a wrap either way.
   always_comb begin
      nxt       = cnt_ext;
      step_wrap = 1'b0;
      if (cnt_ext >= MOD_W) begin
         nxt       = '0;
         step_wrap = 1'b1;
      end else if (bus.up_dn) begin
         if (cnt_ext == MAX_W) begin
            nxt       = '0;
            step_wrap = 1'b1;
         end else begin
            nxt = cnt_ext + ONE_W;
         end
      end else begin
         if (cnt_ext == '0) begin
            nxt       = MAX_W;
            step_wrap = 1'b1;
         end else begin
            nxt = cnt_ext - ONE_W;
         end
      end
   end

   assign wrap_edge = bus.en & ~bus.load & step_wrap;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         tally_q <= '0;
      end else begin
         if (bus.load)
            count_q <= ld_val;
         else if (bus.en)
            count_q <= nxt[WIDTH-1:0];
         wrap_q <= wrap_edge;
         if (bus.tally_clr)
            tally_q <= '0;
         else if (wrap_edge && tally_q != T_MAX)
            tally_q <= tally_q + T_ONE;
      end
   end

   // Zero-latency look-ahead so a following stage steps on our wrap edge.
   assign bus.tc    = bus.en & ~bus.load &
                      ((bus.up_dn & (cnt_ext == MAX_W)) | (~bus.up_dn & (cnt_ext == '0)));
   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
   assign bus.tally = tally_q;
endmodule

// File: doc/mod_counter_gen.md
Name: mod_counter_gen

Overview:
- Parametrised synchronous modulo-N counter. Successor to the fixed 4-bit add-one/comparator-reset counter.
- Adds the following:
  - Configurable width and modulus.
  - Up/down mode.
  - Count enable.
  - Parallel load.
  - Combinational terminal-count output for cascading.
  - Registered one-cycle wrap pulse.
  - Saturating wrap tally.
- Sits between the board clock domain and the LED/display outputs. Multiple instances chain through tc to form multi-digit counters.

Parameters:
- WIDTH, 4, bit width of count and load_val.
- MODULUS, 10, count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH. Elaboration fails otherwise.
- TALLY_W, 4, width of the saturating wrap tally.

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge only.
- reset  in  1  synchronous, active-low reset.
- en  in  1  count enable; one step per clk edge while high.
- up_dn  in  1  direction: 1 = count up, 0 = count down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- tally_clr  in  1  synchronous clear of the wrap tally.
- count  out  WIDTH  current count value.
- tc  out  1  combinational terminal count.
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap edge.
- tally  out  TALLY_W  number of wraps since reset/clear, saturating.

Behaviour:
- Reset (reset=0 at clk edge): count=0, wrap=0, tally=0. Reset overrides load, en and tally_clr. Applying reset mid-count discards state with no partial update.
- Priority per edge, highest first: reset, load, en, hold.
- Load:
  - Sets count = load_val if load_val < MODULUS.
  - Otherwise sets count = MODULUS-1 (clamped).
  - A load never asserts wrap and never increments tally, even if en=1 on the same edge.
- Up mode, en=1: count = count+1. If count == MODULUS-1, the next value is 0 and this is a wrap edge.
- Down mode, en=1: count = count-1. If count == 0, the next value is MODULUS-1 and this is a wrap edge.
- Hold: en=0 and load=0 keeps count unchanged. up_dn may change freely while en=0.
- Arithmetic:
  - Internal next-value logic is computed at WIDTH+1 bits and compared against MODULUS. No intermediate value ≥ MODULUS is ever registered.
  - If the count register is ever found ≥ MODULUS (e.g. after a glitch), the next enabled edge forces it to 0 and asserts wrap.
- tc (combinational): tc = en & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)). It goes high in the cycle before the wrap edge. Feeding tc into the next stage's en makes that stage step on the same edge as this stage's wrap.
- wrap:
  - Registered: wrap = 1 for exactly one cycle following each wrap edge, else 0.
  - Back-to-back wraps (MODULUS=2 continuously enabled, or a stage driven by a fast tc) yield wrap high on consecutive cycles, one per wrap edge.
- tally:
  - Increments by 1 on each wrap edge.
  - Saturates at 2**TALLY_W-1 with no rollover.
- tally_clr:
  - tally_clr=1 sets tally=0 on that edge.
  - If a wrap edge coincides with tally_clr, tally=0 (clear wins). wrap still pulses.
- Latency: count updates 1 cycle after a qualifying edge. wrap is valid in the same cycle the wrapped count is visible. tc has 0 latency.
- Wrap edge defined: an edge where reset=1, load=0, en=1, and the count rolls over (per the up/down rules above).

Test Plan:
- Reset, then up count, MODULUS=10, en=1 for 12 edges → count 1..9,0,1,2. tc high only while count=9. wrap high one cycle when count=0. tally=1.
- Down count, MODULUS=10, start at 0, en=1 for 3 edges → count 9,8,7. wrap pulses after the first edge. tc high while count=0.
- Load priority and clamp:
  - load=1, load_val=13, en=1 at count=9 → count=9 (clamped), wrap=0, tally unchanged.
  - load_val=4 → count=4.
- Saturation and clear:
  - TALLY_W=2, 5 wraps → tally=3.
  - tally_clr on the 6th wrap edge → tally=0, wrap=1.
- Cascade: two instances MODULUS=10, second en = first tc, 100 edges → counts (0,0). Second stage stepped exactly on each first-stage 9→0 edge. Second-stage wrap pulses once.
- Reset mid-operation: count=7, reset=0 for one edge with load=1, en=1 → count=0, wrap=0, tally=0. Counting resumes from 1 on the next enabled edge.
